// File: rtl/cpu7_ifu_fcl_if.sv
// Instruction-bus handshake between the IFU fetch control and the bus adapter.
// The master side issues/cancels requests; the slave side accepts and answers them.
interface cpu7_ifu_fcl_if;
    logic inst_req;
    logic inst_addr_ok;
    logic inst_valid_f;
    logic inst_cancel;

    modport master (
        output inst_req,
        output inst_cancel,
        input  inst_addr_ok,
        input  inst_valid_f
    );

    modport slave (
        input  inst_req,
        input  inst_cancel,
        output inst_addr_ok,
        output inst_valid_f
    );
endinterface

// File: rtl/cpu7_ifu_fcl.sv
// cpu7 IFU fetch control: pc_bf select sequencing, single-outstanding fetch handshake,
// redirect/stall handling. Optional stall skid buffer enabled by CPU7_IFU_FCL_SKID_EN.
module cpu7_ifu_fcl #(
    parameter int BOOT_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    cpu7_ifu_fcl_if.master        ibus,
    input  logic                  br_taken,
    input  logic                  exu_ifu_except,
    input  logic                  exu_ifu_ertn_e,
    input  logic                  exu_ifu_stall_req,
    output logic                  fcl_fdp_pcbf_sel_init_bf_l,
    output logic                  fcl_fdp_pcbf_sel_old_bf_l,
    output logic                  fcl_fdp_pcbf_sel_pcinc_bf_l,
    output logic                  fcl_fdp_pcbf_sel_brpc_bf_l,
    output logic                  fcl_fdp_pcbf_sel_excpc_bf_l,
    output logic                  fcl_fdp_pcbf_sel_ertnpc_bf_l,
    output logic                  fcl_fdp_valid_f,
    output logic                  fcl_fdp_skid_we,
    output logic                  fcl_fdp_skid_sel
);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_WAIT,
        ST_DRAIN
`ifdef CPU7_IFU_FCL_SKID_EN
        , ST_SKID
`endif
    } state_e;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    // select vector bit order: init, old, pcinc, brpc, excpc, ertnpc (active high here)
    localparam int SEL_INIT  = 5;
    localparam int SEL_OLD   = 4;
    localparam int SEL_INC   = 3;
    localparam int SEL_BR    = 2;
    localparam int SEL_EXC   = 1;
    localparam int SEL_ERTN  = 0;

    state_e      state;
    state_e      state_nxt;
    logic [3:0]  boot_cnt;
    logic        boot_done;

    logic        except_v;
    logic        ertn_v;
    logic        br_v;
    logic        rd;
    logic        stall;
    logic        accept;

    logic        req;
    logic        deliver;
    logic        skid_we;
    logic        skid_sel;
    logic [5:0]  sel;

    // Redirect inputs are masked while reset is held so every output sits at its reset value.
    assign except_v = resetn & exu_ifu_except;
    assign ertn_v   = resetn & exu_ifu_ertn_e;
    assign br_v     = resetn & br_taken;
    assign rd       = except_v | ertn_v | br_v;
    // An exception wins over a stall request.
    assign stall    = exu_ifu_stall_req & ~except_v;
    assign accept   = req & ibus.inst_addr_ok;

    assign boot_done = (boot_cnt == BOOT_LAST);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            boot_cnt <= 4'd0;
        end else if (state == ST_BOOT && !boot_done) begin
            boot_cnt <= boot_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_BOOT: begin
                if (boot_done) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (ibus.inst_valid_f) begin
                    if (rd || !stall) begin
                        state_nxt = accept ? ST_WAIT : ST_IDLE;
                    end else begin
`ifdef CPU7_IFU_FCL_SKID_EN
                        state_nxt = ST_SKID;
`else
                        state_nxt = ST_IDLE;
`endif
                    end
                end else if (rd) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ibus.inst_valid_f) state_nxt = accept ? ST_WAIT : ST_IDLE;
            end
`ifdef CPU7_IFU_FCL_SKID_EN
            ST_SKID: begin
                if (rd) begin
                    state_nxt = ST_IDLE;
                end else if (!stall) begin
                    state_nxt = accept ? ST_WAIT : ST_IDLE;
                end
            end
`endif
            default: state_nxt = ST_BOOT;
        endcase
    end

    always_comb begin
        req      = 1'b0;
        deliver  = 1'b0;
        skid_we  = 1'b0;
        skid_sel = 1'b0;
        unique case (state)
            ST_BOOT: begin
            end
            ST_IDLE: begin
                req = ~stall | rd;
            end
            ST_WAIT: begin
                if (ibus.inst_valid_f) begin
                    if (rd) begin
                        req = 1'b1;
                    end else if (!stall) begin
                        req     = 1'b1;
                        deliver = 1'b1;
                    end else begin
`ifdef CPU7_IFU_FCL_SKID_EN
                        skid_we = 1'b1;
`endif
                    end
                end
            end
            ST_DRAIN: begin
                if (ibus.inst_valid_f) req = ~stall | rd;
            end
`ifdef CPU7_IFU_FCL_SKID_EN
            ST_SKID: begin
                if (!rd && !stall) begin
                    req      = 1'b1;
                    deliver  = 1'b1;
                    skid_sel = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_comb begin
        sel = 6'b000000;
        if (except_v) begin
            sel[SEL_EXC] = 1'b1;
        end else if (ertn_v) begin
            sel[SEL_ERTN] = 1'b1;
        end else if (br_v) begin
            sel[SEL_BR] = 1'b1;
        end else if (state == ST_BOOT) begin
            sel[SEL_INIT] = 1'b1;
        end else if (deliver) begin
            sel[SEL_INC] = 1'b1;
        end else begin
            sel[SEL_OLD] = 1'b1;
        end
    end

    assign ibus.inst_req    = req;
    assign ibus.inst_cancel = rd;
    assign fcl_fdp_valid_f  = deliver;

    assign fcl_fdp_pcbf_sel_init_bf_l   = ~sel[SEL_INIT];
    assign fcl_fdp_pcbf_sel_old_bf_l    = ~sel[SEL_OLD];
    assign fcl_fdp_pcbf_sel_pcinc_bf_l  = ~sel[SEL_INC];
    assign fcl_fdp_pcbf_sel_brpc_bf_l   = ~sel[SEL_BR];
    assign fcl_fdp_pcbf_sel_excpc_bf_l  = ~sel[SEL_EXC];
    assign fcl_fdp_pcbf_sel_ertnpc_bf_l = ~sel[SEL_ERTN];

`ifdef CPU7_IFU_FCL_SKID_EN
    assign fcl_fdp_skid_we  = skid_we;
    assign fcl_fdp_skid_sel = skid_sel;
`else
    assign fcl_fdp_skid_we  = 1'b0;
    assign fcl_fdp_skid_sel = 1'b0;
    logic unused_skid;
    assign unused_skid = skid_we | skid_sel;
`endif

    a_sel_onehot: assert property (@(posedge clock) $onehot(sel));
    a_valid_state: assert property (@(posedge clock) disable iff (!resetn)
        fcl_fdp_valid_f |-> (state != ST_BOOT && state != ST_DRAIN && !rd));
    a_cancel_rd: assert property (@(posedge clock) disable iff (!resetn)
        ibus.inst_cancel == rd);

endmodule

// File: tb/tb_cpu7_ifu_fcl.sv
// Self-checking bench for cpu7_ifu_fcl: cycle vectors with expected outputs,
// a small fetch-datapath/bus model to check the PC of every delivered word.
module tb_cpu7_ifu_fcl;

    localparam logic [31:0] PC_INIT = 32'h1c00_0000;
    localparam logic [31:0] BR_PC   = 32'h1c00_0100;
    localparam logic [31:0] EENT    = 32'h1c00_8000;
    localparam logic [31:0] ERA     = 32'h1c00_0040;

    // {init, old, pcinc, brpc, excpc, ertnpc}, active low
    localparam logic [5:0] S_INIT = 6'b011111;
    localparam logic [5:0] S_OLD  = 6'b101111;
    localparam logic [5:0] S_INC  = 6'b110111;
    localparam logic [5:0] S_BR   = 6'b111011;
    localparam logic [5:0] S_EXC  = 6'b111101;
    localparam logic [5:0] S_ERTN = 6'b111110;

    typedef struct {
        bit [63:0]   name;
        bit          rstn, aok, vld, br, exc, ertn, stall;
        bit          req, cancel, valid;
        logic [5:0]  sel;
        bit          swe, ssel;
        logic [31:0] pc;
    } vec_t;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic br_taken = 1'b0;
    logic exu_ifu_except = 1'b0;
    logic exu_ifu_ertn_e = 1'b0;
    logic exu_ifu_stall_req = 1'b0;
    logic sel_init_l, sel_old_l, sel_inc_l, sel_br_l, sel_exc_l, sel_ertn_l;
    logic valid_f, skid_we, skid_sel;

    cpu7_ifu_fcl_if ibus ();

    cpu7_ifu_fcl #(.BOOT_CYCLES(1)) dut (
        .clock                        (clock),
        .resetn                       (resetn),
        .ibus                         (ibus),
        .br_taken                     (br_taken),
        .exu_ifu_except               (exu_ifu_except),
        .exu_ifu_ertn_e               (exu_ifu_ertn_e),
        .exu_ifu_stall_req            (exu_ifu_stall_req),
        .fcl_fdp_pcbf_sel_init_bf_l   (sel_init_l),
        .fcl_fdp_pcbf_sel_old_bf_l    (sel_old_l),
        .fcl_fdp_pcbf_sel_pcinc_bf_l  (sel_inc_l),
        .fcl_fdp_pcbf_sel_brpc_bf_l   (sel_br_l),
        .fcl_fdp_pcbf_sel_excpc_bf_l  (sel_exc_l),
        .fcl_fdp_pcbf_sel_ertnpc_bf_l (sel_ertn_l),
        .fcl_fdp_valid_f              (valid_f),
        .fcl_fdp_skid_we              (skid_we),
        .fcl_fdp_skid_sel             (skid_sel)
    );

    always #5 clock = ~clock;

    // Fetch datapath and bus model: response data is the address of the accepted request.
    logic [5:0]  sel;
    logic [31:0] pc_f = 32'h0;
    logic [31:0] pc_bf;
    logic [31:0] last_addr = 32'h0;
    logic [31:0] skid_buf = 32'h0;
    logic [31:0] word;

    assign sel  = {sel_init_l, sel_old_l, sel_inc_l, sel_br_l, sel_exc_l, sel_ertn_l};
    assign word = skid_sel ? skid_buf : last_addr;

    always_comb begin
        case (sel)
            S_INIT:  pc_bf = PC_INIT;
            S_OLD:   pc_bf = pc_f;
            S_INC:   pc_bf = pc_f + 32'd4;
            S_BR:    pc_bf = BR_PC;
            S_EXC:   pc_bf = EENT;
            S_ERTN:  pc_bf = ERA;
            default: pc_bf = 32'hdead_beef;
        endcase
    end

    always @(posedge clock) begin
        pc_f <= pc_bf;
        if (ibus.inst_req && ibus.inst_addr_ok) last_addr <= pc_bf;
        if (skid_we) skid_buf <= last_addr;
    end

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(bit [63:0] nm, bit rstn, bit aok, bit vld, bit br, bit exc,
                                bit ertn, bit stall, bit req, bit cancel, bit valid,
                                logic [5:0] s, bit swe, bit ssel, logic [31:0] pc);
        vec_t v;
        v.name = nm; v.rstn = rstn; v.aok = aok; v.vld = vld; v.br = br; v.exc = exc;
        v.ertn = ertn; v.stall = stall; v.req = req; v.cancel = cancel; v.valid = valid;
        v.sel = s; v.swe = swe; v.ssel = ssel; v.pc = pc;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        @(posedge clock);
        #1;
        resetn                = v.rstn;
        ibus.inst_addr_ok     = v.aok;
        ibus.inst_valid_f     = v.vld;
        br_taken              = v.br;
        exu_ifu_except        = v.exc;
        exu_ifu_ertn_e        = v.ertn;
        exu_ifu_stall_req     = v.stall;
        exp_q.push_back(v);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            logic [10:0] got, want;
            e    = exp_q.pop_front();
            got  = {ibus.inst_req, ibus.inst_cancel, valid_f, sel, skid_we, skid_sel};
            want = {e.req, e.cancel, e.valid, e.sel, e.swe, e.ssel};
            n_vec++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s: req/cancel/valid/sel/swe/ssel got %b required %b", e.name, got, want);
            end
            if (e.valid) begin
                n_vec++;
                if (word !== e.pc) begin
                    n_bad++;
                    $display("FAIL %s_pc: delivered pc got %h required %h", e.name, word, e.pc);
                end
            end
        end
    end

    initial begin
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_valid_f = 1'b0;

        //              name     rs ao vl br ex er st  rq cn va sel     we ss pc
        tbl.push_back(mk("rst0",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_INIT, 0, 0, 0));
        tbl.push_back(mk("rst1",   0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_INIT, 0, 0, 0));
        tbl.push_back(mk("boot",   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_INIT, 0, 0, 0));
        tbl.push_back(mk("req0",   1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("dlv0",   1, 1, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, PC_INIT));
        tbl.push_back(mk("dlv1",   1, 1, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, PC_INIT + 4));
        tbl.push_back(mk("dlv2",   1, 1, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, PC_INIT + 8));
        tbl.push_back(mk("wait",   1, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("br_wait",1, 0, 0, 1, 0, 0, 0,  0, 1, 0, S_BR,   0, 0, 0));
        tbl.push_back(mk("drain",  1, 1, 1, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("br_tgt", 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, BR_PC));
        tbl.push_back(mk("idle",   1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("exbrst", 1, 1, 1, 1, 1, 0, 1,  1, 1, 0, S_EXC,  0, 0, 0));
        tbl.push_back(mk("ex_dlv", 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, EENT));
        tbl.push_back(mk("idle2",  1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("exwst",  1, 0, 0, 1, 1, 0, 1,  0, 1, 0, S_EXC,  0, 0, 0));
        tbl.push_back(mk("ertn_dr",1, 0, 0, 0, 0, 1, 0,  0, 1, 0, S_ERTN, 0, 0, 0));
        tbl.push_back(mk("drain2", 1, 1, 1, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("er_dlv", 1, 1, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, ERA));
        tbl.push_back(mk("stall1", 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, S_OLD,  0, 0, 0));
`ifdef CPU7_IFU_FCL_SKID_EN
        tbl.push_back(mk("stall2", 1, 0, 1, 0, 0, 0, 1,  0, 0, 0, S_OLD,  1, 0, 0));
        tbl.push_back(mk("stall3", 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("skidrel",1, 1, 0, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 1, ERA + 4));
        tbl.push_back(mk("nxt_dlv",1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, ERA + 8));
`else
        tbl.push_back(mk("stall2", 1, 0, 1, 0, 0, 0, 1,  0, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("stall3", 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("refetch",1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("ref_dlv",1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, ERA + 4));
`endif
        tbl.push_back(mk("idle3",  1, 0, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("br_idle",1, 1, 0, 1, 0, 0, 0,  1, 1, 0, S_BR,   0, 0, 0));
        tbl.push_back(mk("brt_dlv",1, 1, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, BR_PC));
        tbl.push_back(mk("wait2",  1, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("rst_mid",0, 0, 0, 0, 0, 0, 0,  0, 0, 0, S_INIT, 0, 0, 0));
        tbl.push_back(mk("stray1", 1, 0, 1, 0, 0, 0, 0,  0, 0, 0, S_INIT, 0, 0, 0));
        tbl.push_back(mk("stray2", 1, 0, 1, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("req_rs", 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        tbl.push_back(mk("dlv_rs", 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, PC_INIT));

        foreach (tbl[i]) apply(tbl[i]);

        // Response arriving in DRAIN under stall, then an exception issued while stalled in IDLE.
        apply(mk("h_req",  1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        apply(mk("h_br",   1, 0, 0, 1, 0, 0, 0,  0, 1, 0, S_BR,   0, 0, 0));
        apply(mk("h_drst", 1, 0, 1, 0, 0, 0, 1,  0, 0, 0, S_OLD,  0, 0, 0));
        apply(mk("h_idst", 1, 0, 0, 0, 0, 0, 1,  0, 0, 0, S_OLD,  0, 0, 0));
        apply(mk("h_req2", 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        apply(mk("h_dlv",  1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, BR_PC));
        apply(mk("h_exst", 1, 1, 0, 0, 1, 0, 1,  1, 1, 0, S_EXC,  0, 0, 0));
        apply(mk("h_exdl", 1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, EENT));
`ifdef CPU7_IFU_FCL_SKID_EN
        // Redirect while a word sits in the skid buffer drops it.
        apply(mk("m_req",  1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        apply(mk("m_skid", 1, 0, 1, 0, 0, 0, 1,  0, 0, 0, S_OLD,  1, 0, 0));
        apply(mk("m_ertn", 1, 0, 0, 0, 0, 1, 1,  0, 1, 0, S_ERTN, 0, 0, 0));
        apply(mk("m_req2", 1, 1, 0, 0, 0, 0, 0,  1, 0, 0, S_OLD,  0, 0, 0));
        apply(mk("m_dlv",  1, 0, 1, 0, 0, 0, 0,  1, 0, 1, S_INC,  0, 0, ERA));
`endif

        @(posedge clock);
        #1;
        ibus.inst_addr_ok = 1'b0;
        ibus.inst_valid_f = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_q: pending expectations got %0d required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu7_ifu_fcl.md
# cpu7_ifu_fcl

Fetch control logic for the cpu7 IFU. It sequences the fetch PC datapath by driving the one-hot active-low `pc_bf` mux selects. It runs the instruction-bus request/response handshake with at most one request in flight, and qualifies the fetched word delivered to decode. It also handles redirects (exception, ertn, branch), EXU stall requests and discarding of cancelled responses.

## Interface
Parameters:
- BOOT_CYCLES, 1: cycles `pc_init` is held on `pc_bf` after reset release before the first request; legal range 1..15.

Ports:
- clock  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- inst_req  out  1  fetch request to instruction bus
- inst_addr_ok  in  1  request accepted this cycle
- inst_valid_f  in  1  response data valid this cycle
- inst_cancel  out  1  abort of unaccepted request; one pulse per redirect cycle
- br_taken  in  1  branch redirect from _e
- exu_ifu_except  in  1  exception redirect
- exu_ifu_ertn_e  in  1  ertn redirect
- exu_ifu_stall_req  in  1  EXU requests fetch hold
- fcl_fdp_pcbf_sel_init_bf_l  out  1  select pc_init
- fcl_fdp_pcbf_sel_old_bf_l  out  1  select pc_f (hold)
- fcl_fdp_pcbf_sel_pcinc_bf_l  out  1  select pc_f+4
- fcl_fdp_pcbf_sel_brpc_bf_l  out  1  select br_target
- fcl_fdp_pcbf_sel_excpc_bf_l  out  1  select eentry
- fcl_fdp_pcbf_sel_ertnpc_bf_l  out  1  select era
- fcl_fdp_valid_f  out  1  fetched word valid to decode
- fcl_fdp_skid_we  out  1  load skid buffer (CPU7_IFU_FCL_SKID_EN only)
- fcl_fdp_skid_sel  out  1  decode takes skid buffer instead of `inst_rdata_f` (CPU7_IFU_FCL_SKID_EN only)

## Operation
- FSM states: BOOT, IDLE (nothing outstanding), WAIT (one accepted, unanswered), DRAIN (outstanding response to discard), SKID (buffered word pending, macro only).
- Redirect `rd = exu_ifu_except | exu_ifu_ertn_e | br_taken`.
- Select priority, exactly one `_l` low per cycle:
  - except → excpc
  - ertn → ertnpc
  - br_taken → brpc
  - BOOT → init
  - delivered word this cycle → pcinc
  - otherwise → old
- `inst_req = ~stall & (IDLE | (WAIT|DRAIN) & inst_valid_f | SKID-release)`; also asserted on a rd cycle in IDLE, or in WAIT/DRAIN with `inst_valid_f` (target issued same cycle).
- Transitions:
  - BOOT → IDLE after BOOT_CYCLES.
  - IDLE: req & addr_ok → WAIT.
  - WAIT, `inst_valid_f`, no rd, no stall: deliver (`fcl_fdp_valid_f=1`); stay WAIT if a new request is accepted, else IDLE.
  - WAIT, rd without `inst_valid_f` → DRAIN.
  - WAIT, rd with `inst_valid_f`: word dropped; → WAIT if the target request is accepted, else IDLE.
  - DRAIN, `inst_valid_f`: discard; → WAIT if a new request is accepted, else IDLE.
  - DRAIN, further rd: stay DRAIN; the latest target wins via the selects.
- `fcl_fdp_valid_f` is never asserted in BOOT, in DRAIN, on a rd cycle, or on a stall cycle without skid.
- Stall with no macro: a response arriving under stall is discarded, and the state returns to IDLE with sel_old, so the same PC is refetched after the stall.
- Except during stall: exception overrides stall; the select goes to excpc and `inst_req` follows the normal rule.

## Timing
- Reset values:
  - `inst_req=0`, `inst_cancel=0`, `fcl_fdp_valid_f=0`, skid outputs 0.
  - `sel_init_l=0`, all other selects 1.
  - state BOOT, boot counter 0.
- Mid-operation reset returns immediately to these values; any in-flight response after reset is ignored until IDLE.
- Address-to-data latency is bus-defined, minimum 1 cycle.
- Back-to-back delivery gives 1 word per cycle.
- `inst_cancel` is combinational from rd, in the same cycle.
- Redirect to first valid target word: at least 2 cycles from IDLE, at least 3 from WAIT (one drain).
- All outputs except `inst_cancel`, `inst_req` and `fcl_fdp_valid_f` are registered-state decodes plus same-cycle redirect/stall inputs.

## Configuration
- CPU7_IFU_FCL_SKID_EN defined:
  - A response arriving in WAIT under stall (no rd) asserts `fcl_fdp_skid_we` and moves to SKID; select old.
  - On the first non-stall cycle in SKID: `fcl_fdp_valid_f=1`, `fcl_fdp_skid_sel=1`, select pcinc, `inst_req=1`.
  - rd in SKID discards the buffer → IDLE.
- Undefined: SKID state and skid ports are absent (tied 0); stall-time responses are discarded and refetched.

## Test plan
- Reset release, BOOT_CYCLES=1, pc_init=0x1c000000 → init selected 1 cycle, `inst_req=1` in cycle 2, first `fcl_fdp_valid_f` with PC 0x1c000000, then pcinc each cycle under single-cycle bus latency.
- br_taken in WAIT without valid → `inst_cancel` pulse, brpc selected, DRAIN; next `inst_valid_f` not delivered; target delivered after the following response.
- except and br_taken and stall in the same cycle → excpc selected only, `inst_cancel=1`, `fcl_fdp_valid_f=0`.
- Stall for 3 cycles while response arrives in cycle 2 (no macro) → word discarded, sel_old held, same PC refetched after stall drops, delivered once.
- Same stimulus with CPU7_IFU_FCL_SKID_EN → `skid_we` in cycle 2, no refetch, `valid_f`+`skid_sel` in first cycle after stall.
- resetn asserted while in WAIT → all outputs at reset values the same cycle; later stray `inst_valid_f` ignored.
